// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the pattern generator and the receive-side checker.
// Both ends use lfsr_next so that they agree on a single sequence.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH = 24;
    localparam int unsigned LFSR_TAP_A = 8;
    localparam int unsigned LFSR_TAP_B = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 24'h123456;

    // Widest word that lfsr_next supports; callers zero-extend to this width and truncate the result.
    localparam int unsigned LFSR_MAX_W = 64;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lfsr_state_e;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] x,
        input int unsigned           width,
        input int unsigned           tap_a,
        input int unsigned           tap_b
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
        fb   = x[6'(tap_a)] ^ x[6'(tap_b)];
        return ((x << 1) & mask) | LFSR_MAX_W'(fb);
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides with
// an increment loads 1, so the event in that cycle is still counted.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(inc_i);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR stream checker: hunts for a seed, locks after a run of
// correct predictions, then counts mismatches against its own free-running prediction.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = LFSR_WIDTH,
    parameter int unsigned TAP_A      = LFSR_TAP_A,
    parameter int unsigned TAP_B      = LFSR_TAP_B,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic [WIDTH-1:0] last_expected
);

    localparam int unsigned RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
        return WIDTH'(lfsr_next(LFSR_MAX_W'(x), WIDTH, TAP_A, TAP_B));
    endfunction

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [RUN_W-1:0] run_q, run_d, run_nxt;
    logic             seed_q, seed_d;
    logic             err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0] last_exp_q, last_exp_d;
    logic             err_inc, word_inc;

    // Next-state and counter-event decode.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        seed_d      = seed_q;
        err_pulse_d = 1'b0;
        last_exp_d  = clear_cnt ? '0 : last_exp_q;
        err_inc     = 1'b0;
        word_inc    = 1'b0;
        run_nxt     = run_q + RUN_W'(1);

        if (valid_in) begin
            case (state_q)
                HUNT: begin
                    if (!seed_q) begin
                        // Zero is the lock-up state and can never start a sequence.
                        if (data_in != '0) begin
                            exp_d  = nxt(data_in);
                            seed_d = 1'b1;
                            run_d  = '0;
                        end
                    end else if (data_in == exp_q) begin
                        exp_d = nxt(data_in);
                        if (run_nxt == RUN_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_nxt;
                        end
                    end else begin
                        run_d = '0;
                        if (data_in == '0) begin
                            seed_d = 1'b0;
                        end else begin
                            exp_d = nxt(data_in);
                        end
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    // Advance from the prediction so one bad word costs exactly one error.
                    exp_d    = nxt(exp_q);
                    if (data_in == exp_q) begin
                        run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        last_exp_d  = exp_q;
                        if (run_nxt == RUN_W'(LOSS_COUNT)) begin
                            state_d = HUNT;
                            seed_d  = 1'b0;
                            run_d   = '0;
                        end else begin
                            run_d = run_nxt;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            run_q       <= '0;
            seed_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            last_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            seed_q      <= seed_d;
            err_pulse_q <= err_pulse_d;
            last_exp_q  <= last_exp_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (err_inc),
        .clr_i   (clear_cnt),
        .count_o (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (word_inc),
        .clr_i   (clear_cnt),
        .count_o (word_count)
    );

    assign locked        = (state_q == LOCKED);
    assign err_pulse     = err_pulse_q;
    assign last_expected = last_exp_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: default instance plus a CNT_W=4 / LOSS_COUNT=32 instance,
// both compared against a word-level reference model of the checker.
`timescale 1ns/1ps
module tb_lfsr_checker;

    localparam int unsigned W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          r0, v0, c0;
    logic [W-1:0]  d0;
    logic          lk0, ep0;
    logic [15:0]   ec0, wc0;
    logic [W-1:0]  le0;

    logic          r1, v1, c1;
    logic [W-1:0]  d1;
    logic          lk1, ep1;
    logic [3:0]    ec1, wc1;
    logic [W-1:0]  le1;

    lfsr_checker dut0 (
        .clk(clk), .reset(r0), .data_in(d0), .valid_in(v0), .clear_cnt(c0),
        .locked(lk0), .err_pulse(ep0), .err_count(ec0), .word_count(wc0), .last_expected(le0)
    );

    lfsr_checker #(.CNT_W(4), .LOSS_COUNT(32)) dut1 (
        .clk(clk), .reset(r1), .data_in(d1), .valid_in(v1), .clear_cnt(c1),
        .locked(lk1), .err_pulse(ep1), .err_count(ec1), .word_count(wc1), .last_expected(le1)
    );

    typedef struct {
        bit          lck;
        bit          seeded;
        bit          pulse;
        int unsigned expv;
        int unsigned run;
        int unsigned errc;
        int unsigned wordc;
        int unsigned lastexp;
    } mdl_t;

    mdl_t        m0, m1;
    int          total = 0;
    int          bad   = 0;
    int unsigned g0, g1;

    function automatic int unsigned nx(input int unsigned x);
        return ((x * 2) % 32'h0100_0000) | (((x >> 8) ^ (x >> 16)) & 1);
    endfunction

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned cmax);
        return (a >= cmax) ? cmax : a + 1;
    endfunction

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.lck = 0; z.seeded = 0; z.pulse = 0;
        z.expv = 0; z.run = 0; z.errc = 0; z.wordc = 0; z.lastexp = 0;
        return z;
    endfunction

    // One accepted-or-idle cycle of the checker, described word by word.
    task automatic model_step(inout mdl_t m, input int unsigned d, input bit v, input bit clr,
                              input bit rst, input int unsigned lockn, input int unsigned lossn,
                              input int unsigned cmax);
        m.pulse = 0;
        if (rst) begin
            m = mdl_zero();
            return;
        end
        if (clr) begin
            m.errc = 0; m.wordc = 0; m.lastexp = 0;
        end
        if (!v) return;
        if (!m.lck) begin
            if (m.seeded && d == m.expv) begin
                m.run  = m.run + 1;
                m.expv = nx(d);
                if (m.run == lockn) begin
                    m.lck = 1; m.run = 0;
                end
            end else begin
                m.run    = 0;
                m.seeded = (d != 0);
                m.expv   = nx(d);
            end
        end else begin
            m.wordc = sat_add(m.wordc, cmax);
            if (d != m.expv) begin
                m.pulse   = 1;
                m.errc    = sat_add(m.errc, cmax);
                m.lastexp = m.expv;
                m.run     = m.run + 1;
                if (m.run == lossn) begin
                    m.lck = 0; m.seeded = 0; m.run = 0;
                end
            end else begin
                m.run = 0;
            end
            m.expv = nx(m.expv);
        end
    endtask

    function automatic logic [57:0] exp0();
        return {m0.lck, m0.pulse, 16'(m0.errc), 16'(m0.wordc), 24'(m0.lastexp)};
    endfunction

    function automatic logic [33:0] exp1();
        return {m1.lck, m1.pulse, 4'(m1.errc), 4'(m1.wordc), 24'(m1.lastexp)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(m0, 32'(d0), v0, c0, r0, 4, 4, 32'hFFFF);
        model_step(m1, 32'(d1), v1, c1, r1, 4, 32, 15);
        @(negedge clk);
    endtask

    task automatic test_reset();
        r0 = 1; r1 = 1; v0 = 1; d0 = 24'h123456; c0 = 1;
        tick();
        r0 = 0; r1 = 0; v0 = 0; c0 = 0;
        total++;
        if ({lk0, ep0, ec0, wc0, le0} !== 58'd0) begin
            bad++; $display("FAIL reset0 got=%h want=0", {lk0, ep0, ec0, wc0, le0});
        end
        total++;
        if ({lk1, ep1, ec1, wc1, le1} !== 34'd0) begin
            bad++; $display("FAIL reset1 got=%h want=0", {lk1, ep1, ec1, wc1, le1});
        end
    endtask

    task automatic test_lock();
        g0 = 32'h123456;
        for (int i = 0; i < 10; i++) begin
            d0 = 24'(g0); v0 = 1;
            tick();
            g0 = nx(g0);
            total++;
            if (lk0 !== (i >= 4)) begin
                bad++; $display("FAIL lock_time word=%0d got=%0b want=%0b", i, lk0, (i >= 4));
            end
            total++;
            if (wc0 !== 16'((i >= 5) ? i - 4 : 0) || ec0 !== 16'd0) begin
                bad++; $display("FAIL lock_counts word=%0d got wc=%0d ec=%0d", i, wc0, ec0);
            end
            total++;
            if ({lk0, ep0, ec0, wc0, le0} !== exp0()) begin
                bad++; $display("FAIL lock_model got=%h want=%h", {lk0, ep0, ec0, wc0, le0}, exp0());
            end
        end
        v0 = 0;
    endtask

    task automatic test_single_error();
        int unsigned truth;
        for (int i = 0; i < 3; i++) begin
            d0 = 24'(g0); v0 = 1; tick(); g0 = nx(g0);
        end
        truth = g0;
        d0 = 24'(g0 ^ 1); tick(); g0 = nx(g0);
        total++;
        if (ep0 !== 1'b1 || ec0 !== 16'd1 || le0 !== 24'(truth) || lk0 !== 1'b1) begin
            bad++; $display("FAIL single_err got ep=%0b ec=%0d le=%h lk=%0b want 1/1/%h/1",
                            ep0, ec0, le0, lk0, 24'(truth));
        end
        for (int i = 0; i < 5; i++) begin
            d0 = 24'(g0); tick(); g0 = nx(g0);
            total++;
            if (ep0 !== 1'b0 || ec0 !== 16'd1 || lk0 !== 1'b1) begin
                bad++; $display("FAIL after_err got ep=%0b ec=%0d lk=%0b want 0/1/1", ep0, ec0, lk0);
            end
        end
        total++;
        if ({lk0, ep0, ec0, wc0, le0} !== exp0()) begin
            bad++; $display("FAIL single_model got=%h want=%h", {lk0, ep0, ec0, wc0, le0}, exp0());
        end
        v0 = 0;
    endtask

    task automatic test_loss_relock();
        int unsigned base;
        base = m0.errc;
        for (int j = 0; j < 4; j++) begin
            d0 = 24'(g0 ^ $urandom_range(1, 32'hFF_FFFF)); v0 = 1; tick(); g0 = nx(g0);
            total++;
            if (ec0 !== 16'(base + j + 1) || lk0 !== (j < 3)) begin
                bad++; $display("FAIL loss got ec=%0d lk=%0b want ec=%0d lk=%0b",
                                ec0, lk0, base + j + 1, (j < 3));
            end
        end
        for (int j = 0; j < 5; j++) begin
            d0 = 24'(g0); tick(); g0 = nx(g0);
            total++;
            if (lk0 !== (j == 4) || ec0 !== 16'(base + 4) || ep0 !== 1'b0) begin
                bad++; $display("FAIL relock word=%0d got lk=%0b ec=%0d want lk=%0b ec=%0d",
                                j, lk0, ec0, (j == 4), base + 4);
            end
        end
        v0 = 0;
    endtask

    task automatic test_zero_seed();
        r0 = 1; tick(); r0 = 0;
        for (int j = 0; j < 2; j++) begin
            d0 = '0; v0 = 1; tick();
            total++;
            if (lk0 !== 1'b0 || wc0 !== 16'd0) begin
                bad++; $display("FAIL zero_word got lk=%0b wc=%0d want 0/0", lk0, wc0);
            end
        end
        for (int j = 0; j < 5; j++) begin
            d0 = 24'(g0); tick(); g0 = nx(g0);
            total++;
            if (lk0 !== (j == 4)) begin
                bad++; $display("FAIL zero_lock word=%0d got=%0b want=%0b", j, lk0, (j == 4));
            end
        end
        v0 = 0;
    endtask

    task automatic test_gaps();
        r0 = 1; tick(); r0 = 0;
        for (int i = 0; i < 80; i++) begin
            v0 = ($urandom_range(0, 2) != 0);
            d0 = v0 ? 24'(g0) : 24'($urandom);
            if (v0) g0 = nx(g0);
            tick();
            total++;
            if ({lk0, ep0, ec0, wc0, le0} !== exp0()) begin
                bad++; $display("FAIL gaps cyc=%0d got=%h want=%h", i, {lk0, ep0, ec0, wc0, le0}, exp0());
            end
        end
        v0 = 0;
        total++;
        if (lk0 !== 1'b1 || ec0 !== 16'd0) begin
            bad++; $display("FAIL gaps_end got lk=%0b ec=%0d want 1/0", lk0, ec0);
        end
    endtask

    task automatic test_clear_event();
        int unsigned truth;
        truth = g0;
        d0 = 24'(g0 ^ 4); v0 = 1; c0 = 1; tick(); g0 = nx(g0);
        total++;
        if (ec0 !== 16'd1 || wc0 !== 16'd1 || le0 !== 24'(truth) || ep0 !== 1'b1) begin
            bad++; $display("FAIL clr_err got ec=%0d wc=%0d le=%h ep=%0b want 1/1/%h/1",
                            ec0, wc0, le0, ep0, 24'(truth));
        end
        d0 = 24'(g0); tick(); g0 = nx(g0);
        total++;
        if (ec0 !== 16'd0 || wc0 !== 16'd1 || le0 !== 24'd0 || lk0 !== 1'b1) begin
            bad++; $display("FAIL clr_word got ec=%0d wc=%0d le=%h lk=%0b want 0/1/0/1", ec0, wc0, le0, lk0);
        end
        v0 = 0; tick();
        total++;
        if (wc0 !== 16'd0 || lk0 !== 1'b1) begin
            bad++; $display("FAIL clr_idle got wc=%0d lk=%0b want 0/1", wc0, lk0);
        end
        c0 = 0;
    endtask

    task automatic test_random();
        int burst = 0;
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            c0 = ($urandom_range(0, 31) == 0);
            r0 = ($urandom_range(0, 149) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(2, 6);
            if (!v0) begin
                d0 = 24'($urandom);
            end else if (burst > 0) begin
                d0 = 24'(g0 ^ $urandom_range(1, 32'hFF_FFFF)); burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                d0 = '0;
            end else if ($urandom_range(0, 11) == 0) begin
                d0 = 24'(g0 ^ (1 << $urandom_range(0, 23)));
            end else begin
                d0 = 24'(g0);
            end
            if (v0) g0 = nx(g0);
            tick();
            total++;
            if ({lk0, ep0, ec0, wc0, le0} !== exp0()) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, {lk0, ep0, ec0, wc0, le0}, exp0());
            end
        end
        v0 = 0; c0 = 0; r0 = 0;
    endtask

    task automatic test_saturation();
        g1 = 32'hABCDEF;
        for (int j = 0; j < 5; j++) begin
            d1 = 24'(g1); v1 = 1; tick(); g1 = nx(g1);
            total++;
            if (lk1 !== (j == 4)) begin
                bad++; $display("FAIL sat_lock word=%0d got=%0b want=%0b", j, lk1, (j == 4));
            end
        end
        for (int j = 0; j < 20; j++) begin
            d1 = 24'(g1 ^ $urandom_range(1, 32'hFF_FFFF)); tick(); g1 = nx(g1);
            total++;
            if (ec1 !== 4'((j < 15) ? j + 1 : 15) || wc1 !== 4'((j < 15) ? j + 1 : 15)
                || lk1 !== 1'b1 || ep1 !== 1'b1) begin
                bad++; $display("FAIL sat_err n=%0d got ec=%0d wc=%0d lk=%0b ep=%0b", j + 1, ec1, wc1, lk1, ep1);
            end
            total++;
            if ({lk1, ep1, ec1, wc1, le1} !== exp1()) begin
                bad++; $display("FAIL sat_model got=%h want=%h", {lk1, ep1, ec1, wc1, le1}, exp1());
            end
        end
        v1 = 0; c1 = 1; tick(); c1 = 0;
        total++;
        if (ec1 !== 4'd0 || wc1 !== 4'd0 || le1 !== 24'd0 || lk1 !== 1'b1) begin
            bad++; $display("FAIL sat_clear got ec=%0d wc=%0d le=%h lk=%0b want 0/0/0/1", ec1, wc1, le1, lk1);
        end
        for (int j = 0; j < 3; j++) begin
            d1 = 24'(g1); v1 = 1; tick(); g1 = nx(g1);
            total++;
            if (wc1 !== 4'(j + 1) || ec1 !== 4'd0 || ep1 !== 1'b0) begin
                bad++; $display("FAIL sat_resume got wc=%0d ec=%0d want %0d/0", wc1, ec1, j + 1);
            end
        end
        r1 = 1; d1 = 24'(g1 ^ 1); tick(); r1 = 0; v1 = 0;
        total++;
        if ({lk1, ep1, ec1, wc1, le1} !== 34'd0) begin
            bad++; $display("FAIL sat_reset got=%h want=0", {lk1, ep1, ec1, wc1, le1});
        end
    endtask

    initial begin
        r0 = 1; v0 = 0; c0 = 0; d0 = '0;
        r1 = 1; v1 = 0; c1 = 0; d1 = '0;
        m0 = mdl_zero();
        m1 = mdl_zero();
        @(negedge clk);
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_zero_seed();
        test_gaps();
        test_clear_event();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side counterpart of the team's 24-bit Fibonacci LFSR pattern generator.
- Sits at the far end of a data path under test (e.g. the read side of the async FIFO). It self-synchronises to the incoming LFSR word stream, predicts each next word, and counts mismatches.
- Delivers pass/fail status and error statistics to the bench or status registers.

Parameters:
- WIDTH, 24, LFSR word width.
- TAP_A, 8, first feedback tap bit index.
- TAP_B, 16, second feedback tap bit index.
- LOCK_COUNT, 4, consecutive correct predictions needed to declare lock (≥1).
- LOSS_COUNT, 4, consecutive mismatches while locked that drop lock (≥1).
- CNT_W, 16, width of the error and word counters.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  received word.
- valid_in  in  1  data_in is valid this cycle. No backpressure: the checker accepts every valid word.
- clear_cnt  in  1  synchronous clear of the counters only; state and lock are kept.
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle pulse for each mismatching word accepted while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.
- word_count  out  CNT_W  saturating count of words accepted while LOCKED.
- last_expected  out  WIDTH  predicted value of the most recent mismatching word.

Behaviour:
- Sequence definition: next(x) = {x[WIDTH-2:0], x[TAP_A] ^ x[TAP_B]}. Example: next(0x123456) = 0x2468AC.
- Internal registers:
  - state: HUNT or LOCKED.
  - exp: the predicted next word.
  - run: consecutive-event counter.
  - have_seed: 1 bit.
- Reset (synchronous, active-high):
  - state=HUNT, exp=0, run=0, have_seed=0.
  - All outputs 0: locked=0, err_pulse=0, err_count=0, word_count=0, last_expected=0.
  - Reset overrides all other inputs in the same cycle. Reset mid-stream discards lock, and hunting restarts with the next valid word.
- All outputs are registered. A word accepted in cycle N is reflected in the outputs in cycle N+1.
- Cycles with valid_in=0 change nothing; err_pulse deasserts.
- HUNT:
  - If have_seed=0 and data_in≠0: exp←next(data_in), have_seed←1, run←0. An all-zero word is never taken as a seed, because zero is the LFSR lock-up state.
  - If have_seed=1 and data_in==exp: run←run+1, exp←next(data_in).
    - If run+1==LOCK_COUNT, go to LOCKED and set run←0.
  - If have_seed=1 and data_in≠exp: re-seed from data_in (exp←next(data_in), run←0). If data_in==0, clear have_seed instead.
  - In HUNT, err_count and word_count do not change and err_pulse stays 0.
- LOCKED:
  - Every accepted word increments word_count, saturating at all-ones.
  - Match: run←0.
  - Mismatch:
    - err_pulse=1 next cycle.
    - err_count increments, saturating.
    - last_expected←exp.
    - run←run+1.
  - exp always advances from the prediction (exp←next(exp)), never from data_in, so one corrupted word counts as exactly one error.
  - When run+1==LOSS_COUNT on a mismatch: go to HUNT with have_seed=0 and run=0.
- clear_cnt zeroes err_count, word_count and last_expected.
  - If a counting event occurs in the same cycle, the counters load the event's contribution (0 or 1) instead of incrementing.
- Counter saturation: the counters hold at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package lfsr_pkg holds:
  - the state enum (HUNT, LOCKED);
  - a lfsr_next function parameterised by the WIDTH, TAP_A and TAP_B values;
  - the default constants LFSR_WIDTH=24, LFSR_TAP_A=8, LFSR_TAP_B=16, LFSR_SEED=24'h123456.
- The generator is expected to migrate to lfsr_pkg too, so both ends share one definition.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice for err_count and word_count.

Test Plan:
1. Reset, then feed a clean sequence from seed 0x123456 (0x123456, 0x2468AC, 0x48D158, 0x91A2B1, …) with valid_in=1 -> locked=1 one cycle after the 5th word is accepted (seed plus 4 matches); err_count=0; word_count increments from the 6th word.
2. While locked, replace one word with word^0x000001 -> exactly one err_pulse; err_count=1; last_expected=the true word; the following clean words produce no errors.
3. While locked, send 4 consecutive garbage words -> err_count=4 and locked=0 after the 4th. Resume the clean sequence -> re-lock after 5 further words.
4. In HUNT, send 0x000000 twice, then the clean sequence -> the zeros are ignored as seeds; lock follows 5 clean words.
5. Drive valid_in with random gaps over a clean stream -> lock and counting are unaffected by the gaps; err_count stays 0.
6. With CNT_W=4, force 20 errors using LOSS_COUNT=32 -> err_count saturates at 15. Pulse clear_cnt -> counters read 0 next cycle. Assert reset mid-stream -> all outputs 0 the next cycle.
